// File: rtl/gps_trip_pkg.sv
// Shared defaults, FSM encoding and saturation limits for the trip-statistics block.
package gps_trip_pkg;

  localparam int DW_DEF = 40;
  localparam int SW_DEF = 48;
  localparam int CW_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    DIV  = 1'b1
  } state_t;

  localparam logic [SW_DEF-1:0] SUM_MAX = {SW_DEF{1'b1}};
  localparam logic [CW_DEF-1:0] CNT_MAX = {CW_DEF{1'b1}};

endpackage

// File: rtl/gps_serial_div.sv
// Restoring bit-serial divider: one quotient bit per cycle, MSB first, SW cycles.
// quot holds the last completed result; it only changes on the final iteration
// edge (together with the done pulse) or when aborted.
module gps_serial_div #(
  parameter int SW = 48,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  input  logic [SW-1:0] dividend,
  input  logic [CW-1:0] divisor,
  output logic [SW-1:0] quot,
  output logic          done,
  output logic          last
);

  localparam int NW = $clog2(SW + 1);

  logic [SW-1:0] q;
  logic [CW-1:0] rem;
  logic [CW-1:0] dvs;
  logic [NW-1:0] cnt;
  logic          run;

  logic [CW:0]   trial;
  logic          fits;
  logic [CW-1:0] rem_next;
  logic [SW-1:0] q_next;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // The remainder is always below the divisor, so the trial fits in CW+1 bits.
  always_comb begin
    trial    = {rem, q[SW-1]};
    fits     = (trial >= {1'b0, dvs});
    rem_next = fits ? CW'(trial - {1'b0, dvs}) : trial[CW-1:0];
    q_next   = {q[SW-2:0], fits};
    last     = run && (cnt == NW'(1));
  end

  // Iteration registers; the down-counter's terminal count marks the last step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q    <= '0;
      rem  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      quot <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        run  <= 1'b0;
        cnt  <= '0;
        quot <= '0;
      end else if (start) begin
        q   <= dividend;
        rem <= '0;
        dvs <= divisor;
        cnt <= NW'(SW);
        run <= 1'b1;
      end else if (run) begin
        q   <= q_next;
        rem <= rem_next;
        cnt <= cnt - NW'(1);
        if (last) begin
          run  <= 1'b0;
          quot <= q_next;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gps_trip_stat.sv
// Trip statistics: saturating total, segment count, longest segment and the
// running mean (via a serial divider), with a one-entry pending buffer for
// samples that arrive while a division is in progress.
//
// state | meaning
// IDLE  | no division running; a sample (pending first) is accepted here
// DIV   | divider iterating; new samples go to the pending slot or are dropped
module gps_trip_stat
  import gps_trip_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int SW = SW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          DIST_VALID,
  input  logic [DW-1:0] DIST,
  input  logic          CLR,
  output logic [SW-1:0] SUM,
  output logic [CW-1:0] SEG_CNT,
  output logic [DW-1:0] MAX_D,
  output logic [SW-1:0] AVG,
  output logic          AVG_VALID,
  output logic          BUSY,
  output logic          OVF
);

  state_t        state, state_nxt;
  logic          pend;
  logic [DW-1:0] pend_d;

  logic          apply_pend, accept_new, load, drop;
  logic [DW-1:0] load_d;
  logic [SW:0]   sum_add;
  logic [SW-1:0] sum_new;
  logic          cnt_sat;
  logic [CW-1:0] cnt_new;
  logic          div_last;

  // Accept decode and saturating next values for the statistics.
  // A pending sample always wins over a fresh one in IDLE so order is kept.
  always_comb begin
    apply_pend = (state == IDLE) && pend && !CLR;
    accept_new = (state == IDLE) && !pend && DIST_VALID && !CLR;
    load       = apply_pend || accept_new;
    drop       = (state == DIV) && DIST_VALID && pend && !CLR;
    load_d     = pend ? pend_d : DIST;
    sum_add    = {1'b0, SUM} + (SW+1)'(load_d);
    sum_new    = sum_add[SW] ? SUM_MAX : sum_add[SW-1:0];
    cnt_sat    = (SEG_CNT == CNT_MAX);
    cnt_new    = cnt_sat ? SEG_CNT : SEG_CNT + CW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // FSM next state: CLR aborts, a load enters DIV, the last iteration returns.
  always_comb begin
    state_nxt = state;
    if (CLR) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (load) state_nxt = DIV;
        DIV:     if (div_last) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    BUSY = (state == DIV) || pend;
  end

  // Accumulators and sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      SUM     <= '0;
      SEG_CNT <= '0;
      MAX_D   <= '0;
      OVF     <= 1'b0;
    end else if (CLR) begin
      SUM     <= '0;
      SEG_CNT <= '0;
      MAX_D   <= '0;
      OVF     <= 1'b0;
    end else begin
      if (load) begin
        SUM     <= sum_new;
        SEG_CNT <= cnt_new;
        if (load_d > MAX_D) MAX_D <= load_d;
        if (sum_add[SW] || cnt_sat) OVF <= 1'b1;
      end
      if (drop) OVF <= 1'b1;
    end
  end

  // One-entry pending buffer; refilled in the same edge it is drained.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend   <= 1'b0;
      pend_d <= '0;
    end else if (CLR) begin
      pend <= 1'b0;
    end else if ((state == DIV) && DIST_VALID && !pend) begin
      pend   <= 1'b1;
      pend_d <= DIST;
    end else if (apply_pend) begin
      pend <= DIST_VALID;
      if (DIST_VALID) pend_d <= DIST;
    end
  end

  gps_serial_div #(
    .SW(SW),
    .CW(CW)
  ) u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (load),
    .abort    (CLR),
    .dividend (sum_new),
    .divisor  (cnt_new),
    .quot     (AVG),
    .done     (AVG_VALID),
    .last     (div_last)
  );

endmodule

// File: tb/tb_gps_trip_stat.sv
// Bench for gps_trip_stat: cycle-level behavioural model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_gps_trip_stat;
  import gps_trip_pkg::*;

  localparam int DW = 40;
  localparam int SW = 48;
  localparam int CW = 16;
  localparam longint unsigned SMAX = 64'h0000_FFFF_FFFF_FFFF;
  localparam longint unsigned CMAX = 64'h0000_0000_0000_FFFF;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          DIST_VALID = 1'b0;
  logic [DW-1:0] DIST = '0;
  logic          CLR = 1'b0;
  logic [SW-1:0] SUM;
  logic [CW-1:0] SEG_CNT;
  logic [DW-1:0] MAX_D;
  logic [SW-1:0] AVG;
  logic          AVG_VALID;
  logic          BUSY;
  logic          OVF;

  gps_trip_stat dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .DIST_VALID (DIST_VALID),
    .DIST       (DIST),
    .CLR        (CLR),
    .SUM        (SUM),
    .SEG_CNT    (SEG_CNT),
    .MAX_D      (MAX_D),
    .AVG        (AVG),
    .AVG_VALID  (AVG_VALID),
    .BUSY       (BUSY),
    .OVF        (OVF)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int busy_cnt = 0;
  longint unsigned avg_log[$];
  int              avg_cyc[$];

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: statistics as plain integers, the mean as one division,
  // and the division latency as an end-cycle number.
  longint unsigned m_sum = 0, m_cnt = 0, m_max = 0, m_avg = 0, m_q = 0, m_pd = 0;
  bit m_av = 0, m_ovf = 0, m_act = 0, m_pend = 0;
  int m_end = 0;

  task automatic m_apply(input longint unsigned d);
    m_sum = m_sum + d;
    if (m_sum > SMAX) begin
      m_sum = SMAX;
      m_ovf = 1;
    end
    if (m_cnt == CMAX) m_ovf = 1;
    else m_cnt = m_cnt + 1;
    if (d > m_max) m_max = d;
    m_q   = m_sum / m_cnt;
    m_end = cyc + SW;
    m_act = 1;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        cyc = 0;
        m_sum = 0; m_cnt = 0; m_max = 0; m_avg = 0;
        m_av = 0; m_ovf = 0; m_act = 0; m_pend = 0;
      end else begin
        cyc++;
        m_av = 0;
        if (CLR) begin
          m_sum = 0; m_cnt = 0; m_max = 0; m_avg = 0;
          m_ovf = 0; m_act = 0; m_pend = 0;
        end else if (m_act) begin
          if (DIST_VALID) begin
            if (m_pend) m_ovf = 1;
            else begin
              m_pend = 1;
              m_pd   = DIST;
            end
          end
          if (cyc == m_end) begin
            m_avg = m_q;
            m_av  = 1;
            m_act = 0;
          end
        end else if (m_pend) begin
          m_apply(m_pd);
          m_pend = DIST_VALID;
          m_pd   = DIST;
        end else if (DIST_VALID) begin
          m_apply(DIST);
        end
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        chk("sum",       SUM,       m_sum);
        chk("seg_cnt",   SEG_CNT,   m_cnt);
        chk("max_d",     MAX_D,     m_max);
        chk("avg",       AVG,       m_avg);
        chk("avg_valid", AVG_VALID, m_av);
        chk("busy",      BUSY,      longint'(m_act || m_pend));
        chk("ovf",       OVF,       m_ovf);
        if (AVG_VALID) begin
          avg_log.push_back(AVG);
          avg_cyc.push_back(cyc);
        end
        if (BUSY) busy_cnt++;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [DW-1:0] d);
    DIST_VALID = 1'b1;
    DIST       = d;
    @(negedge clk);
    DIST_VALID = 1'b0;
    DIST       = '0;
    last_acc   = cyc;
  endtask

  task automatic clr();
    CLR = 1'b1;
    @(negedge clk);
    CLR = 1'b0;
  endtask

  function automatic longint unsigned avg_at(input int i);
    return (i < avg_log.size()) ? avg_log[i] : 64'hDEAD_BEEF;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < avg_cyc.size()) ? avg_cyc[i] : -1;
  endfunction

  int n0;
  int a0;

  initial begin
    // Reset held
    idle(5);
    chk("rst_sum", SUM, 0);
    chk("rst_seg_cnt", SEG_CNT, 0);
    chk("rst_max_d", MAX_D, 0);
    chk("rst_avg", AVG, 0);
    chk("rst_avg_valid", AVG_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_ovf", OVF, 0);
    reset_n = 1'b1;
    idle(100);
    chk("idle_sum", SUM, 0);
    chk("idle_busy", BUSY, 0);

    // Single segment
    busy_cnt = 0;
    n0 = avg_log.size();
    send(40'd100);
    a0 = last_acc;
    chk("single_sum", SUM, 100);
    chk("single_cnt", SEG_CNT, 1);
    chk("single_max", MAX_D, 100);
    idle(60);
    chk("single_busy_len", busy_cnt, 48);
    chk("single_avg", avg_at(n0), 100);
    chk("single_avg_lat", cyc_at(n0) - a0, 48);

    // Spaced sequence 100, 300, 200
    clr();
    idle(2);
    n0 = avg_log.size();
    send(40'd100);
    idle(59);
    send(40'd300);
    idle(59);
    send(40'd200);
    idle(60);
    chk("seq_npulse", avg_log.size() - n0, 3);
    chk("seq_avg0", avg_at(n0), 100);
    chk("seq_avg1", avg_at(n0 + 1), 200);
    chk("seq_avg2", avg_at(n0 + 2), 200);
    chk("seq_sum", SUM, 600);
    chk("seq_cnt", SEG_CNT, 3);
    chk("seq_max", MAX_D, 300);

    // Back-to-back with pending slot, then a dropped third sample
    clr();
    idle(2);
    n0 = avg_log.size();
    send(40'd10);
    a0 = last_acc;
    idle(1);
    send(40'd20);
    chk("b2b_busy", BUSY, 1);
    idle(5);
    send(40'd30);
    chk("b2b_ovf", OVF, 1);
    idle(110);
    chk("b2b_avg0", avg_at(n0), 10);
    chk("b2b_lat0", cyc_at(n0) - a0, 48);
    chk("b2b_avg1", avg_at(n0 + 1), 15);
    chk("b2b_lat1", cyc_at(n0 + 1) - a0, 97);
    chk("b2b_sum", SUM, 30);
    chk("b2b_cnt", SEG_CNT, 2);
    chk("b2b_ovf_sticky", OVF, 1);

    // Sum saturation: 256 samples just fit, the 257th clamps
    clr();
    idle(2);
    for (int i = 0; i < 257; i++) begin
      send(40'hFF_FFFF_FFFF);
      if (i == 255) begin
        chk("sat_sum_256", SUM, 64'h0000_FFFF_FFFF_FF00);
        chk("sat_ovf_256", OVF, 0);
      end
      idle(52);
    end
    idle(10);
    chk("sat_sum", SUM, 64'h0000_FFFF_FFFF_FFFF);
    chk("sat_ovf", OVF, 1);
    chk("sat_cnt", SEG_CNT, 257);
    chk("sat_avg", avg_at(avg_log.size() - 1), 64'h0000_00FF_00FF_00FF);

    // CLR mid-division together with a new sample
    clr();
    idle(2);
    send(40'd50);
    idle(19);
    n0 = avg_log.size();
    CLR = 1'b1;
    DIST_VALID = 1'b1;
    DIST = 40'd77;
    @(negedge clk);
    CLR = 1'b0;
    DIST_VALID = 1'b0;
    DIST = '0;
    chk("clr_sum", SUM, 0);
    chk("clr_cnt", SEG_CNT, 0);
    chk("clr_max", MAX_D, 0);
    chk("clr_busy", BUSY, 0);
    chk("clr_ovf", OVF, 0);
    idle(60);
    chk("clr_no_avg", avg_log.size() - n0, 0);
    chk("clr_cnt_after", SEG_CNT, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
